// File: rtl/neon_axil_regs_if.sv
// AXI4-Lite bus bundle for the neon_axil_regs register block.
// The master modport is the driving side (interconnect / VIP), the slave
// modport is the register block.
interface neon_axil_regs_if #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6
);
    logic [C_S_AXI_ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]                      awprot;
    logic                            awvalid;
    logic                            awready;
    logic [C_S_AXI_DATA_WIDTH-1:0]   wdata;
    logic [C_S_AXI_DATA_WIDTH/8-1:0] wstrb;
    logic                            wvalid;
    logic                            wready;
    logic [1:0]                      bresp;
    logic                            bvalid;
    logic                            bready;
    logic [C_S_AXI_ADDR_WIDTH-1:0]   araddr;
    logic [2:0]                      arprot;
    logic                            arvalid;
    logic                            arready;
    logic [C_S_AXI_DATA_WIDTH-1:0]   rdata;
    logic [1:0]                      rresp;
    logic                            rvalid;
    logic                            rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/neon_axil_regs.sv
// AXI4-Lite responder with four 32-bit R/W registers for the Neon core.
// AW and W are accepted independently (one write, one read outstanding),
// byte strobes are honoured and wr_pulse_o flags each committed register.
// Optional feature: define NEON_AXIL_SLVERR_EN to answer out-of-range
// addresses with SLVERR; otherwise addresses wrap onto the four registers.
module neon_axil_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6
) (
    input  logic                          s00_axi_aclk,
    input  logic                          s00_axi_aresetn,
    neon_axil_regs_if.slave               s00_axi,
    output logic [C_S_AXI_DATA_WIDTH-1:0] reg0_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0] reg1_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0] reg2_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0] reg3_o,
    output logic [3:0]                    wr_pulse_o
);
    localparam int DATA_W = C_S_AXI_DATA_WIDTH;
    localparam int ADDR_W = C_S_AXI_ADDR_WIDTH;
    localparam int STRB_W = DATA_W / 8;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_HOLD, W_RESP} w_state_t;

    w_state_t            r_wstate;
    w_state_t            w_wstate_nxt;
    logic                r_live;      // set on the first edge after reset release
    logic                r_have_aw;   // in W_HOLD: 1 = AW captured, 0 = W captured
    logic [ADDR_W-1:0]   r_awaddr;
    logic [DATA_W-1:0]   r_wdata;
    logic [STRB_W-1:0]   r_wstrb;
    logic [DATA_W-1:0]   r_regs [4];
    logic [3:0]          r_wr_pulse;
    logic [1:0]          r_bresp;
    logic                r_rvalid;
    logic [DATA_W-1:0]   r_rdata;
    logic [1:0]          r_rresp;

    logic                w_awready;
    logic                w_wready;
    logic                w_bvalid;
    logic                w_aw_hs;
    logic                w_w_hs;
    logic                w_commit;
    logic                w_ar_hs;
    logic [ADDR_W-1:0]   w_wr_addr;
    logic [DATA_W-1:0]   w_wr_data;
    logic [STRB_W-1:0]   w_wr_strb;
    logic [1:0]          w_wr_sel;
    logic [1:0]          w_rd_sel;
    logic                w_wr_ok;
    logic                w_rd_ok;
    logic                w_unused;

    // Write FSM state register plus the "out of reset" flag gating the readies.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge value of every other flop, independent of block ordering.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_wstate <= W_IDLE;
            r_live   <= 1'b0;
        end else begin
            r_wstate <= w_wstate_nxt;
            r_live   <= 1'b1;
        end
    end

    // Write FSM: readies/bvalid from state, handshakes, commit and next state.
    // NOTE: every output gets a default before the case so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    always_comb begin
        w_wstate_nxt = r_wstate;
        w_awready    = 1'b0;
        w_wready     = 1'b0;
        w_bvalid     = 1'b0;
        w_commit     = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                w_awready = r_live;
                w_wready  = r_live;
            end
            W_HOLD: begin
                w_awready = !r_have_aw;
                w_wready  = r_have_aw;
            end
            W_RESP:  w_bvalid = 1'b1;
            default: ;
        endcase
        w_aw_hs = s00_axi.awvalid && w_awready;
        w_w_hs  = s00_axi.wvalid && w_wready;
        case (r_wstate)
            W_IDLE: begin
                if (w_aw_hs && w_w_hs) begin
                    w_commit     = 1'b1;
                    w_wstate_nxt = W_RESP;
                end else if (w_aw_hs || w_w_hs) begin
                    w_wstate_nxt = W_HOLD;
                end
            end
            W_HOLD: begin
                if (w_aw_hs || w_w_hs) begin
                    w_commit     = 1'b1;
                    w_wstate_nxt = W_RESP;
                end
            end
            W_RESP:  if (s00_axi.bready) w_wstate_nxt = W_IDLE;
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    // The committing write takes each half from the register if it was captured earlier.
    assign w_wr_addr = (r_wstate == W_HOLD && r_have_aw)  ? r_awaddr : s00_axi.awaddr;
    assign w_wr_data = (r_wstate == W_HOLD && !r_have_aw) ? r_wdata  : s00_axi.wdata;
    assign w_wr_strb = (r_wstate == W_HOLD && !r_have_aw) ? r_wstrb  : s00_axi.wstrb;
    assign w_wr_sel  = w_wr_addr[3:2];
    assign w_rd_sel  = s00_axi.araddr[3:2];
    assign w_ar_hs   = s00_axi.arvalid && r_live && !r_rvalid;

`ifdef NEON_AXIL_SLVERR_EN
    assign w_wr_ok = (w_wr_addr[ADDR_W-1:4] == '0);
    assign w_rd_ok = (s00_axi.araddr[ADDR_W-1:4] == '0);
`else
    assign w_wr_ok = 1'b1;
    assign w_rd_ok = 1'b1;
`endif

    // Hold whichever channel arrived first while waiting for its partner.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_have_aw <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
        end else if (r_wstate == W_IDLE && !w_commit) begin
            if (w_aw_hs) begin
                r_have_aw <= 1'b1;
                r_awaddr  <= s00_axi.awaddr;
            end else if (w_w_hs) begin
                r_have_aw <= 1'b0;
                r_wdata   <= s00_axi.wdata;
                r_wstrb   <= s00_axi.wstrb;
            end
        end
    end

    // Register file update, one-cycle write pulse and write response.
    // NOTE: the register array is reset like any other flop because the core
    // depends on reading zeros after reset; it is small enough to stay in flops.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            for (int i = 0; i < 4; i++) r_regs[i] <= '0;
            r_wr_pulse <= '0;
            r_bresp    <= RESP_OKAY;
        end else begin
            r_wr_pulse <= '0;
            if (w_commit) begin
                r_bresp <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
                if (w_wr_ok) begin
                    for (int k = 0; k < STRB_W; k++) begin
                        if (w_wr_strb[k]) r_regs[w_wr_sel][8*k +: 8] <= w_wr_data[8*k +: 8];
                    end
                    r_wr_pulse <= 4'b0001 << w_wr_sel;
                end
            end
        end
    end

    // Read channel: sample the register (pre-write value on a same-edge commit)
    // and hold it until rready; rdata returns to zero once the beat is taken.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
        end else if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_ok ? r_regs[w_rd_sel] : '0;
            r_rresp  <= w_rd_ok ? RESP_OKAY : RESP_SLVERR;
        end else if (r_rvalid && s00_axi.rready) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end
    end

    assign s00_axi.awready = w_awready;
    assign s00_axi.wready  = w_wready;
    assign s00_axi.bvalid  = w_bvalid;
    assign s00_axi.bresp   = r_bresp;
    assign s00_axi.arready = r_live && !r_rvalid;
    assign s00_axi.rvalid  = r_rvalid;
    assign s00_axi.rdata   = r_rdata;
    assign s00_axi.rresp   = r_rresp;

    assign reg0_o     = r_regs[0];
    assign reg1_o     = r_regs[1];
    assign reg2_o     = r_regs[2];
    assign reg3_o     = r_regs[3];
    assign wr_pulse_o = r_wr_pulse;

    // Protection bits and the byte-offset / wrapped address bits carry no meaning here.
    assign w_unused = ^{s00_axi.awprot, s00_axi.arprot, s00_axi.awaddr,
                        s00_axi.araddr, r_awaddr, w_wr_addr};
endmodule

// File: tb/tb_neon_axil_regs.sv
// Self-checking bench for neon_axil_regs: directed scenarios followed by
// randomized reads/writes, all compared against a word-array register model.
`timescale 1ns/1ps
module tb_neon_axil_regs;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] reg0, reg1, reg2, reg3;
    logic [3:0]  wr_pulse;

    always #5 clk = ~clk;

    neon_axil_regs_if #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(6)) axi ();

    neon_axil_regs dut (
        .s00_axi_aclk    (clk),
        .s00_axi_aresetn (rst_n),
        .s00_axi         (axi),
        .reg0_o          (reg0),
        .reg1_o          (reg1),
        .reg2_o          (reg2),
        .reg3_o          (reg3),
        .wr_pulse_o      (wr_pulse)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model [4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        check({tag, "_reg0"}, reg0, model[0]);
        check({tag, "_reg1"}, reg1, model[1]);
        check({tag, "_reg2"}, reg2, model[2]);
        check({tag, "_reg3"}, reg3, model[3]);
    endtask

    // Register targeted by a byte address, or -1 when the access is out of range.
    function automatic int target(input logic [5:0] a);
        int word = int'(a) / 4;
`ifdef NEON_AXIL_SLVERR_EN
        return (word < 4) ? word : -1;
`else
        return word % 4;
`endif
    endfunction

    // Full write: AW/W presented after independent delays, B accepted after b_dly cycles.
    // Called and returns at a negedge with all master inputs idle.
    task automatic do_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int b_dly);
        int         tgt;
        logic [3:0] exp_pulse;
        logic [1:0] exp_resp;
        bit         aw_done = 0, w_done = 0, aw_hs, w_hs;
        int         cyc = 0;
        tgt       = target(addr);
        exp_pulse = (tgt >= 0) ? 4'(1 << tgt) : 4'b0000;
        exp_resp  = (tgt >= 0) ? 2'b00 : 2'b10;
        while (!(aw_done && w_done)) begin
            axi.awvalid = !aw_done && (cyc >= aw_dly);
            axi.awaddr  = addr;
            axi.wvalid  = !w_done && (cyc >= w_dly);
            axi.wdata   = data;
            axi.wstrb   = strb;
            check_bit("wr_awready", axi.awready, !aw_done);
            check_bit("wr_wready", axi.wready, !w_done);
            check_bit("wr_bvalid_early", axi.bvalid, 1'b0);
            check("wr_pulse_early", 32'(wr_pulse), 32'h0);
            check_regs("wr_before");
            aw_hs = axi.awvalid && axi.awready;
            w_hs  = axi.wvalid && axi.wready;
            cyc++;
            if (cyc > 64) begin
                n_checks++;
                n_fail++;
                $error("FAIL write_timeout: observed %0d cycles expected at most 64", cyc);
                axi.awvalid = 1'b0;
                axi.wvalid  = 1'b0;
                return;
            end
            @(negedge clk);
            aw_done = aw_done || aw_hs;
            w_done  = w_done || w_hs;
        end
        axi.awvalid = 1'b0;
        axi.wvalid  = 1'b0;
        if (tgt >= 0) begin
            for (int k = 0; k < 4; k++) if (strb[k]) model[tgt][8*k +: 8] = data[8*k +: 8];
        end
        check_bit("wr_bvalid", axi.bvalid, 1'b1);
        check("wr_bresp", 32'(axi.bresp), 32'(exp_resp));
        check("wr_pulse", 32'(wr_pulse), 32'(exp_pulse));
        check_bit("wr_resp_awready", axi.awready, 1'b0);
        check_bit("wr_resp_wready", axi.wready, 1'b0);
        check_regs("wr_after");
        for (int i = 0; i < b_dly; i++) begin
            @(negedge clk);
            check_bit("wr_hold_bvalid", axi.bvalid, 1'b1);
            check("wr_hold_bresp", 32'(axi.bresp), 32'(exp_resp));
            check_bit("wr_hold_awready", axi.awready, 1'b0);
            check_bit("wr_hold_wready", axi.wready, 1'b0);
            check("wr_hold_pulse", 32'(wr_pulse), 32'h0);
        end
        axi.bready = 1'b1;
        @(negedge clk);
        axi.bready = 1'b0;
        check_bit("wr_done_bvalid", axi.bvalid, 1'b0);
        check_bit("wr_done_awready", axi.awready, 1'b1);
        check_bit("wr_done_wready", axi.wready, 1'b1);
        check("wr_done_pulse", 32'(wr_pulse), 32'h0);
    endtask

    // Full read: AR after ar_dly idle cycles, R accepted after r_dly cycles.
    task automatic do_read(input logic [5:0] addr, input int ar_dly, input int r_dly);
        int          tgt;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        tgt      = target(addr);
        exp_data = 32'h0;
        if (tgt >= 0) exp_data = model[tgt];
        exp_resp = (tgt >= 0) ? 2'b00 : 2'b10;
        repeat (ar_dly) @(negedge clk);
        check_bit("rd_arready", axi.arready, 1'b1);
        check_bit("rd_rvalid_idle", axi.rvalid, 1'b0);
        check("rd_rdata_idle", axi.rdata, 32'h0);
        axi.arvalid = 1'b1;
        axi.araddr  = addr;
        @(negedge clk);
        axi.arvalid = 1'b0;
        check_bit("rd_rvalid", axi.rvalid, 1'b1);
        check("rd_rdata", axi.rdata, exp_data);
        check("rd_rresp", 32'(axi.rresp), 32'(exp_resp));
        check_bit("rd_busy_arready", axi.arready, 1'b0);
        for (int i = 0; i < r_dly; i++) begin
            @(negedge clk);
            check_bit("rd_hold_rvalid", axi.rvalid, 1'b1);
            check("rd_hold_rdata", axi.rdata, exp_data);
        end
        axi.rready = 1'b1;
        @(negedge clk);
        axi.rready = 1'b0;
        check_bit("rd_done_rvalid", axi.rvalid, 1'b0);
        check("rd_done_rdata", axi.rdata, 32'h0);
        check_bit("rd_done_arready", axi.arready, 1'b1);
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish within 200 us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        axi.awvalid = 1'b0; axi.awaddr = '0; axi.awprot = '0;
        axi.wvalid  = 1'b0; axi.wdata  = '0; axi.wstrb  = '0;
        axi.bready  = 1'b0;
        axi.arvalid = 1'b0; axi.araddr = '0; axi.arprot = '0;
        axi.rready  = 1'b0;
        for (int i = 0; i < 4; i++) model[i] = 32'h0;

        // Reset state, then release at 200 ns (a negedge).
        repeat (20) @(negedge clk);
        check_bit("rst_awready", axi.awready, 1'b0);
        check_bit("rst_wready", axi.wready, 1'b0);
        check_bit("rst_arready", axi.arready, 1'b0);
        check_bit("rst_bvalid", axi.bvalid, 1'b0);
        check_bit("rst_rvalid", axi.rvalid, 1'b0);
        check("rst_bresp", 32'(axi.bresp), 32'h0);
        check("rst_rresp", 32'(axi.rresp), 32'h0);
        check("rst_rdata", axi.rdata, 32'h0);
        check("rst_pulse", 32'(wr_pulse), 32'h0);
        check_regs("rst");
        rst_n = 1'b1;
        #1;
        check_bit("rel_awready", axi.awready, 1'b0);
        @(negedge clk);
        check_bit("live_awready", axi.awready, 1'b1);
        check_bit("live_wready", axi.wready, 1'b1);
        check_bit("live_arready", axi.arready, 1'b1);

        // Write 1..4 to the four registers, then read them back.
        for (int i = 0; i < 4; i++) do_write(6'(4 * i), 32'(i + 1), 4'hF, 0, 0, 0);
        for (int i = 0; i < 4; i++) do_read(6'(4 * i), 0, 0);
        check("basic_reg3", reg3, 32'h4);

        // AR handshake and write commit to 0x04 on the same edge.
        check_bit("same_arready", axi.arready, 1'b1);
        check_bit("same_awready", axi.awready, 1'b1);
        axi.awvalid = 1'b1; axi.awaddr = 6'h04;
        axi.wvalid  = 1'b1; axi.wdata  = 32'h5; axi.wstrb = 4'hF;
        axi.arvalid = 1'b1; axi.araddr = 6'h04;
        @(negedge clk);
        axi.awvalid = 1'b0; axi.wvalid = 1'b0; axi.arvalid = 1'b0;
        model[1] = 32'h5;
        check_bit("same_rvalid", axi.rvalid, 1'b1);
        check("same_rdata_old", axi.rdata, 32'h2);
        check_bit("same_bvalid", axi.bvalid, 1'b1);
        check("same_reg1", reg1, 32'h5);
        check("same_pulse", 32'(wr_pulse), 32'h2);
        axi.bready = 1'b1; axi.rready = 1'b1;
        @(negedge clk);
        axi.bready = 1'b0; axi.rready = 1'b0;
        check_bit("same_bvalid_done", axi.bvalid, 1'b0);
        check_bit("same_rvalid_done", axi.rvalid, 1'b0);
        do_read(6'h04, 0, 0);

        // W three cycles ahead of AW.
        do_write(6'h08, 32'hDEADBEEF, 4'hF, 3, 0, 0);
        check("wfirst_reg2", reg2, 32'hDEADBEEF);

        // Partial byte strobes.
        do_write(6'h04, 32'h11223344, 4'hF, 0, 0, 0);
        do_write(6'h04, 32'hAABBCCDD, 4'b0101, 0, 0, 0);
        check("strb_reg1", reg1, 32'h11BB33DD);

        // B back-pressure for 5 cycles, then an immediate follow-on write.
        do_write(6'h0C, 32'h0BADF00D, 4'hF, 0, 0, 5);
        do_write(6'h0C, 32'h600DCAFE, 4'hF, 0, 0, 0);

        // Zero strobes: register unchanged, pulse and OKAY still produced.
        do_write(6'h08, 32'h12345678, 4'h0, 0, 1, 0);
        check("nostrb_reg2", reg2, 32'hDEADBEEF);

        // Address beyond the four registers.
        do_write(6'h10, 32'hCAFEF00D, 4'hF, 0, 0, 0);
        do_read(6'h10, 0, 0);
`ifdef NEON_AXIL_SLVERR_EN
        check("oor_reg0", reg0, 32'h1);
`else
        check("oor_reg0", reg0, 32'hCAFEF00D);
`endif

        // Reset while AW is held: everything cleared, AW discarded.
        axi.awvalid = 1'b1; axi.awaddr = 6'h0C;
        @(negedge clk);
        axi.awvalid = 1'b0;
        check_bit("midrst_hold_wready", axi.wready, 1'b1);
        check_bit("midrst_hold_awready", axi.awready, 1'b0);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) model[i] = 32'h0;
        check_bit("midrst_awready", axi.awready, 1'b0);
        check_bit("midrst_wready", axi.wready, 1'b0);
        check_bit("midrst_bvalid", axi.bvalid, 1'b0);
        check_regs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_bit("midrst_idle_awready", axi.awready, 1'b1);
        check_bit("midrst_idle_wready", axi.wready, 1'b1);
        do_write(6'h00, 32'hA5A5A5A5, 4'hF, 2, 0, 0);
        check("midrst_reg3", reg3, 32'h0);

        // Randomized traffic against the model.
        for (int n = 0; n < 60; n++) begin
            logic [5:0] a;
            a = ($urandom_range(0, 3) != 0) ? 6'($urandom_range(0, 15)) : 6'($urandom_range(0, 63));
            if ($urandom_range(0, 1) == 1)
                do_write(a, $urandom, 4'($urandom_range(0, 15)),
                         $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            else
                do_read(a, $urandom_range(0, 2), $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/neon_axil_regs.md
# neon_axil_regs

AXI4-Lite responder exposing four 32-bit read/write registers to the Neon IP datapath. It sits behind the AXI interconnect as the slave end of the S00_AXI port that the block-design master VIP drives. It accepts AW and W channels independently with one write and one read outstanding, honours byte strobes, and pulses a per-register write strobe toward the core.

## Interface
- C_S_AXI_DATA_WIDTH, 32, data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 6, byte address width; registers at 0x00, 0x04, 0x08, 0x0C.
- s00_axi_aclk  in  1  the single clock; all logic is rising-edge.
- s00_axi_aresetn  in  1  asynchronous, active-low reset.
- s00_axi_awaddr  in  C_S_AXI_ADDR_WIDTH  write address.
- s00_axi_awprot  in  3  ignored.
- s00_axi_awvalid / s00_axi_awready  in / out  1  AW handshake.
- s00_axi_wdata  in  32  write data.
- s00_axi_wstrb  in  4  byte lane enables.
- s00_axi_wvalid / s00_axi_wready  in / out  1  W handshake.
- s00_axi_bresp  out  2  write response.
- s00_axi_bvalid / s00_axi_bready  out / in  1  B handshake.
- s00_axi_araddr  in  C_S_AXI_ADDR_WIDTH  read address.
- s00_axi_arprot  in  3  ignored.
- s00_axi_arvalid / s00_axi_arready  in / out  1  AR handshake.
- s00_axi_rdata  out  32  read data.
- s00_axi_rresp  out  2  read response.
- s00_axi_rvalid / s00_axi_rready  out / in  1  R handshake.
- reg0_o .. reg3_o  out  32 each  current register contents, to core.
- wr_pulse_o  out  4  one-hot, one cycle, bit n set when regn is written.

## Operation
- Address decode uses addr[C_S_AXI_ADDR_WIDTH-1:2]. Indices 0–3 are in range. addr[1:0] is ignored.
- Write FSM has three states.
  - W_IDLE: awready=1, wready=1.
  - W_HOLD: one channel captured. Only the other channel's ready is high.
  - W_RESP: bvalid=1, both readies 0.
- On the edge where the second of AW/W completes, either in the same cycle as the first or later:
  - the target register is updated per byte lane with wstrb[k] → bits[8k+7:8k];
  - wr_pulse_o[n] is high for the following cycle only;
  - the FSM enters W_RESP.
- A write with wstrb=0 leaves the register unchanged, still pulses wr_pulse_o, and still responds OKAY.
- W_RESP → W_IDLE on bvalid&&bready.
- Read path:
  - arready = !rvalid.
  - On AR handshake, rdata/rresp are registered and rvalid rises the next cycle.
  - rvalid holds with stable data until rready; rdata is 0 when rvalid=0.
- Simultaneous read and write commit to the same register on one edge: the read returns the pre-write value.
- The read and write paths are fully independent and never stall each other.

## Timing
- Reset (async assert, sync-released by the clock domain): all ready and valid signals are 0, bresp/rresp=2'b00, rdata=0, reg0_o..reg3_o=0, wr_pulse_o=0. The FSM is in W_IDLE.
- awready, wready and arready rise on the first clock edge after reset deassertion.
- Write latency: bvalid high 1 cycle after the completing AW/W handshake edge; reg*_o updates on that same edge.
- Read latency: rvalid high 1 cycle after the AR handshake.
- Back-to-back: the next AW/W is accepted the cycle after the B handshake, and the next AR the cycle after the R handshake. Maximum throughput is one transaction per 2 cycles per direction.
- Reset asserted mid-transaction aborts it immediately. Any partially captured AW/W is discarded and registers return to 0.
- bvalid and rvalid never drop without a handshake. Payload is stable while valid.

## Configuration
- NEON_AXIL_SLVERR_EN defined:
  - Out-of-range write: no register is updated, wr_pulse_o stays 0, bresp=2'b10 (SLVERR).
  - Out-of-range read: rdata=0, rresp=2'b10.
- Not defined: the address wraps modulo 4 registers (index = addr[3:2]) and every response is OKAY (2'b00).

## Test plan
- Release reset after 200 ns; write 0x1, 0x2, 0x3, 0x4 to 0x00, 0x04, 0x08, 0x0C, then read them back → rdata 0x1..0x4, all resp OKAY, and wr_pulse_o 0001, 0010, 0100, 1000 in turn.
- Present W three cycles before AW at 0x08 with data 0xDEADBEEF → wready handshake alone, bvalid=0 until the AW handshake, then bvalid exactly 1 cycle later and reg2_o=0xDEADBEEF.
- Reg1=0x11223344; write 0xAABBCCDD with wstrb=4'b0101 → reg1_o=0x11BB33DD.
- Hold bready=0 for 5 cycles after a write → bvalid stays 1, awready=wready=0 throughout, and the next write is accepted the cycle after the handshake.
- Same-edge read of 0x04 and write commit of 0x5 to 0x04, with prior value 0x2 → rdata=0x2, and a subsequent read returns 0x5.
- Write then read at 0x10:
  - with NEON_AXIL_SLVERR_EN: bresp=rresp=2'b10, registers unchanged, rdata=0;
  - without it: reg0 is written, and the read returns the written value with OKAY.
